// File: rtl/covox_sample_buffer_pkg.sv
// Shared constants and types for the buffered Covox sample path.
// Contents:
//   PORT_COVOX      - I/O port low byte that carries Covox samples
//   SAMPLE_MID      - DAC midscale value, output while nothing has been played
//   DEF_*           - default FIFO depth, playback divider and prefill threshold
//   play_state_t    - playback state encoding (FILL / PLAY)
package covox_sample_buffer_pkg;

    localparam logic [7:0] PORT_COVOX     = 8'hFB;
    localparam logic [7:0] SAMPLE_MID     = 8'h80;

    localparam int         DEF_DEPTH_LOG2 = 4;
    localparam int         DEF_RATE_DIV   = 160;
    localparam int         DEF_PREFILL    = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PLAY = 1'b1
    } play_state_t;

endpackage

// File: rtl/covox_sample_buffer_if.sv
// Z80 bus view of the Covox port.
// Signals:
//   a        - address low byte
//   d        - data bus
//   n_wr     - write strobe, active-low
//   n_iorq   - I/O request, active-low
//   n_m1     - M1 cycle marker, active-low
//   port_hit - combinational address match back to bus control
// Modports:
//   master - the bus side (drives address/data/strobes, sees port_hit)
//   slave  - the sample buffer (sees address/data/strobes, drives port_hit)
interface covox_sample_buffer_if;

    logic [7:0] a;
    logic [7:0] d;
    logic       n_wr;
    logic       n_iorq;
    logic       n_m1;
    logic       port_hit;

    modport master (
        output a, d, n_wr, n_iorq, n_m1,
        input  port_hit
    );

    modport slave (
        input  a, d, n_wr, n_iorq, n_m1,
        output port_hit
    );

endinterface

// File: rtl/covox_sample_buffer_sync_fifo.sv
// Single-clock FIFO holding Covox samples between the CPU and the playback timer.
// Ports:
//   clk, n_rst - clock and synchronous active-low reset (clears pointers and count)
//   push, din  - write request and data; accepted when not full, or when a pop
//                happens on the same edge
//   pop, dout  - read request and current head (dout is valid whenever !empty)
//   full/empty - occupancy flags
//   level      - occupancy count, 0..2**DEPTH_LOG2
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (cnt == DEPTH_LVL);
    assign empty = (cnt == '0);
    assign level = cnt;
    assign dout  = mem[rd_ptr];

    // When full, a simultaneous pop frees the head slot; the write lands in it
    // on the same edge while the old head is still read out combinationally.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (DEPTH_LOG2 + 1)'(1);
                2'b01:   cnt <= cnt - (DEPTH_LOG2 + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/covox_sample_buffer.sv
// Buffered Covox/Soundrive sample port. CPU OUTs to the Covox port are queued
// and replayed to the DAC modulator at a fixed rate so write jitter never
// reaches the analog output.
// Ports:
//   clk, n_rst   - system clock, synchronous active-low reset
//   bus          - Z80 bus view (address, data, strobes, port_hit)
//   sample       - current sample to the DAC modulator (midscale after reset)
//   sample_tick  - one-clk pulse on the cycle sample may change
//   level        - FIFO occupancy
//   overflow     - sticky: a write was dropped because the FIFO was full
//   underrun     - one-clk pulse: a playback tick found the FIFO empty
module covox_sample_buffer
    import covox_sample_buffer_pkg::*;
#(
    parameter logic [7:0] PORT       = PORT_COVOX,
    parameter int         DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int         RATE_DIV   = DEF_RATE_DIV,
    parameter int         PREFILL    = DEF_PREFILL
) (
    input  logic                    clk,
    input  logic                    n_rst,
    covox_sample_buffer_if.slave    bus,
    output logic [7:0]              sample,
    output logic                    sample_tick,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overflow,
    output logic                    underrun
);

    localparam int                   CNT_W       = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(RATE_DIV - 1);
    localparam logic [DEPTH_LOG2:0]  PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    logic             wr_hit;
    logic             wr_q;
    logic             push;
    logic             pop;
    logic             tick;
    logic             full;
    logic             empty;
    logic [7:0]       head;
    logic [CNT_W-1:0] cnt_q;
    play_state_t      state_q;
    play_state_t      state_d;
    logic             underrun_d;

    // Bus decode
    assign bus.port_hit = (bus.a == PORT);
    assign wr_hit       = !bus.n_iorq && bus.n_m1 && !bus.n_wr && bus.port_hit;

    // One push per I/O cycle: only the first clock of a held strobe counts.
    assign push = wr_hit && !wr_q;

    // wr_q tracks wr_hit even while in reset, so a strobe still held when
    // reset releases is treated as already seen and does not push.
    always_ff @(posedge clk) begin
        wr_q <= wr_hit;
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .din   (bus.d),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Playback rate divider
    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Playback FSM. Decisions use the occupancy before this edge's push, so a
    // write landing on a tick into an empty FIFO cannot be played immediately.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        underrun_d = 1'b0;
        if (tick) begin
            case (state_q)
                ST_FILL: begin
                    if (level >= PREFILL_LVL) begin
                        state_d = ST_PLAY;
                        pop     = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_FILL;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_tick <= tick;
            underrun    <= underrun_d;
            // A pop on the same edge makes room, so that write is not dropped.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output sample register, midscale until the first sample is played.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sample <= SAMPLE_MID;
        end else if (pop) begin
            sample <= head;
        end
    end

endmodule
